sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25: requester/memory byte-address width.
REQ-002 Parameter STARVE_MAX, default 4: consecutive port-0 grants tolerated while port 1 or 2 waits.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_in  in  1  synchronous, active-high reset.
REQ-005 req  in  3  per-requester request level; bit 0 = video DMA, bit 1 = CPU, bit 2 = aux/audio.
REQ-006 wr  in  3  per-requester direction: 1 = write, 0 = read.
REQ-007 addr  in  3*ADDR_W  per-requester address; requester n occupies slice n.
REQ-008 wdata  in  96  per-requester write data, 32 bits each.
REQ-009 bytesel  in  12  per-requester byte enables, 4 bits each.
REQ-010 ack  out  3  one-cycle completion pulse per requester.
REQ-011 rdata  out  32  shared read data; valid only in the cycle the ack bit of a read is high.
REQ-012 mem_req, mem_wr  out  1 each  request and direction to the SDRAM controller.
REQ-013 mem_addr  out  ADDR_W; mem_wdata  out  32; mem_bytesel  out  4: latched transaction fields.
REQ-014 mem_ack  in  1  controller has accepted the request.
REQ-015 mem_rvalid  in  1; mem_rdata  in  32: read data return.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and WAIT_READ, with one outstanding transaction at a time.
REQ-017 In IDLE with any req bit high, the FSM SHALL latch the winner's wr/addr/wdata/bytesel, record the grant index, and enter ISSUE, with mem_req high from the next cycle.
REQ-018 Priority: port 0 SHALL win over ports 1 and 2 unless starve_cnt equals STARVE_MAX.
- When that limit is reached and port 1 or 2 is pending, the round-robin winner of ports 1/2 SHALL win instead.
REQ-019 Round-robin: when ports 1 and 2 both request, the port not granted most recently SHALL win; after reset, port 1 is preferred.
REQ-020 starve_cnt SHALL increment, saturating at STARVE_MAX, on each port-0 grant made while req[1] or req[2] is high.
- starve_cnt SHALL clear on any grant to port 1 or 2.
- starve_cnt SHALL hold on a port-0 grant with no other requester pending.
REQ-021 In ISSUE, mem_req and all mem_* fields SHALL stay constant until mem_ack is sampled high.
- mem_req SHALL drop in the following cycle.
REQ-022 Write: mem_ack sampled high at cycle A SHALL produce ack[grant]=1 at A+1 with the FSM in IDLE at A+1.
- The earliest next mem_req is therefore A+2.
REQ-023 Read: mem_ack sampled high moves the FSM to WAIT_READ.
- mem_rvalid sampled high at cycle R SHALL produce rdata=mem_rdata(R) and ack[grant]=1 at R+1, returning to IDLE.
REQ-024 mem_rvalid SHALL be ignored in IDLE and ISSUE; mem_ack SHALL be ignored outside ISSUE.
REQ-025 At most one ack bit SHALL be high in any cycle; ack SHALL never be asserted for a requester that was not granted.
REQ-026 A requester deasserting req after its grant SHALL NOT abort the transaction; it completes and ack still pulses.
REQ-027 Requests arriving in the same cycle as an ack pulse SHALL be arbitrated in that cycle (FSM is in IDLE).
- This includes a re-request from the port just acknowledged.

Reset
REQ-028 reset_in high SHALL force, on the next edge, FSM=IDLE, mem_req=0, mem_wr=0, ack=0, starve_cnt=0 and round-robin preference to port 1.
- mem_addr, mem_wdata, mem_bytesel and rdata SHALL be reset to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it without any ack pulse.
- A subsequent mem_rvalid SHALL be ignored, since the FSM is in IDLE.

Verification
REQ-030 Single write, port 1, addr=0x0000100, wdata=0xDEADBEEF, bytesel=0xF; mem_ack 3 cycles after mem_req -> mem_* fields match, ack[1] pulses exactly one cycle after mem_ack.
REQ-031 Read, port 2, addr=0x0000040; mem_rvalid with mem_rdata=0x12345678 five cycles after mem_ack -> rdata=0x12345678 with ack[2] on the next cycle.
REQ-032 req=3'b111 held continuously, STARVE_MAX=4 -> grant sequence 0,0,0,0,1,0,0,0,0,2,0,0,0,0,1.
REQ-033 req[0] low, req[1] and req[2] held high -> grants alternate 1,2,1,2, starting with port 1 after reset.
REQ-034 reset_in pulsed while in WAIT_READ, then mem_rvalid -> no ack pulse, mem_req=0, next request is granted normally from IDLE.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bundle between three memory requesters and the SDRAM controller.
// The master modport is the arbiter side.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic [2:0]          req;
  logic [2:0]          wr;
  logic [3*ADDR_W-1:0] addr;
  logic [95:0]         wdata;
  logic [11:0]         bytesel;
  logic [2:0]          ack;
  logic [31:0]         rdata;
  logic                mem_req;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_bytesel;
  logic                mem_ack;
  logic                mem_rvalid;
  logic [31:0]         mem_rdata;

  modport master (
    input  req, wr, addr, wdata, bytesel,
    input  mem_ack, mem_rvalid, mem_rdata,
    output ack, rdata,
    output mem_req, mem_wr, mem_addr,
    output mem_wdata, mem_bytesel
  );

  modport slave (
    output req, wr, addr, wdata, bytesel,
    output mem_ack, mem_rvalid, mem_rdata,
    input  ack, rdata,
    input  mem_req, mem_wr, mem_addr,
    input  mem_wdata, mem_bytesel
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM arbiter: port 0 priority with starvation
// relief, round-robin between ports 1 and 2, one txn in flight.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic reset_in,
  sdram_port_arbiter_if.master bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_READ
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    grant;
  logic [1:0]    win;
  logic [1:0]    rr_win;
  logic [CW-1:0] starve;
  logic          pref_two;
  logic          pend12;
  logic          grab;
  logic          done;

  always_comb begin
    pend12 = bus.req[1] | bus.req[2];
    rr_win = bus.req[1] ? 2'd1 : 2'd2;
    if (bus.req[1] && bus.req[2])
      rr_win = pref_two ? 2'd2 : 2'd1;
    win = rr_win;
    unique case (1'b1)
      bus.req[0] && !(starve == SMAX && pend12):
        win = 2'd0;
      default: win = rr_win;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (|bus.req) state_nxt = ISSUE;
      ISSUE:
        if (bus.mem_ack)
          state_nxt = bus.mem_wr ? IDLE : WAIT_READ;
      WAIT_READ:
        if (bus.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req = (state == ISSUE);
    grab = (state == IDLE) && (|bus.req);
    done = ((state == ISSUE) && bus.mem_ack && bus.mem_wr)
        || ((state == WAIT_READ) && bus.mem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      grant           <= 2'd0;
      starve          <= '0;
      pref_two        <= 1'b0;
      bus.ack         <= 3'b000;
      bus.rdata       <= '0;
      bus.mem_wr      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_bytesel <= '0;
    end else begin
      bus.ack <= done ? (3'b001 << grant) : 3'b000;
      if (state == WAIT_READ && bus.mem_rvalid)
        bus.rdata <= bus.mem_rdata;
      if (grab) begin
        grant           <= win;
        bus.mem_wr      <= bus.wr[win];
        bus.mem_addr    <= bus.addr[int'(win)*ADDR_W +: ADDR_W];
        bus.mem_wdata   <= bus.wdata[int'(win)*32 +: 32];
        bus.mem_bytesel <= bus.bytesel[int'(win)*4 +: 4];
        if (win == 2'd0) begin
          if (pend12 && starve != SMAX)
            starve <= starve + 1'b1;
        end else begin
          starve   <= '0;
          pref_two <= (win == 2'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter; the bench plays the
// requesters and the SDRAM controller.
module tb_sdram_port_arbiter;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  int bad_ack = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(25)) bif ();

  sdram_port_arbiter #(
    .ADDR_W(25),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .bus(bif.master)
  );

  always @(negedge clk)
    if ($countones(bif.ack) > 1) bad_ack++;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
  endtask

  task automatic serve(output int g);
    int n = 0;
    while (!bif.mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!bif.mem_req) begin
      check("mem_req_timeout", 0, 1);
      g = -1;
    end else begin
      g = int'(bif.mem_addr);
      bif.mem_ack = 1'b1;
      tick();
      bif.mem_ack = 1'b0;
    end
  endtask

  int exp_a[15] = '{0,0,0,0,1,0,0,0,0,2,0,0,0,0,1};
  int exp_b[4]  = '{1,2,1,2};

  initial begin
    int g;
    bif.req = 3'b000;
    bif.wr = 3'b000;
    bif.addr = '0;
    bif.wdata = '0;
    bif.bytesel = '0;
    bif.mem_ack = 1'b0;
    bif.mem_rvalid = 1'b0;
    bif.mem_rdata = '0;
    do_reset();

    check("rst_mem_req", bif.mem_req, 0);
    check("rst_mem_wr", bif.mem_wr, 0);
    check("rst_ack", bif.ack, 0);
    check("rst_mem_addr", bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_wdata, 0);
    check("rst_rdata", bif.rdata, 0);

    // single write on port 1, req dropped right after grant
    bif.req = 3'b010;
    bif.wr = 3'b010;
    bif.addr[25 +: 25] = 25'h0000100;
    bif.wdata[32 +: 32] = 32'hDEADBEEF;
    bif.bytesel[4 +: 4] = 4'hF;
    tick();
    bif.req = 3'b000;
    check("w_mem_req", bif.mem_req, 1);
    check("w_mem_wr", bif.mem_wr, 1);
    check("w_mem_addr", bif.mem_addr, 25'h100);
    check("w_mem_wdata", bif.mem_wdata, 32'hDEADBEEF);
    check("w_mem_bytesel", bif.mem_bytesel, 4'hF);
    bif.mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w_hold_req", bif.mem_req, 1);
      check("w_hold_addr", bif.mem_addr, 25'h100);
      check("w_no_ack", bif.ack, 0);
    end
    bif.mem_rvalid = 1'b0;
    bif.mem_ack = 1'b1;
    tick();
    bif.mem_ack = 1'b0;
    check("w_ack", bif.ack, 3'b010);
    check("w_req_drop", bif.mem_req, 0);
    tick();
    check("w_ack_pulse", bif.ack, 0);
    check("w_idle", bif.mem_req, 0);

    // read on port 2, stray rvalid during ISSUE ignored
    bif.req = 3'b100;
    bif.wr = 3'b000;
    bif.addr[50 +: 25] = 25'h0000040;
    tick();
    bif.req = 3'b000;
    check("r_mem_req", bif.mem_req, 1);
    check("r_mem_wr", bif.mem_wr, 0);
    check("r_mem_addr", bif.mem_addr, 25'h40);
    bif.mem_ack = 1'b1;
    bif.mem_rvalid = 1'b1;
    bif.mem_rdata = 32'hBAD0BAD0;
    tick();
    bif.mem_ack = 1'b0;
    bif.mem_rvalid = 1'b0;
    check("r_req_drop", bif.mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_wait_no_ack", bif.ack, 0);
    end
    bif.mem_rvalid = 1'b1;
    bif.mem_rdata = 32'h12345678;
    tick();
    bif.mem_rvalid = 1'b0;
    check("r_ack", bif.ack, 3'b100);
    check("r_rdata", bif.rdata, 32'h12345678);
    tick();
    check("r_ack_pulse", bif.ack, 0);

    // all three requesting: starvation relief pattern
    do_reset();
    bif.wr = 3'b111;
    bif.addr = {25'd2, 25'd1, 25'd0};
    bif.req = 3'b111;
    for (int i = 0; i < 15; i++) begin
      serve(g);
      check($sformatf("starve_grant%0d", i), g, exp_a[i]);
    end
    bif.req = 3'b000;
    tick();
    tick();

    // ports 1 and 2 only: strict alternation from reset
    do_reset();
    bif.req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      serve(g);
      check($sformatf("rr_grant%0d", i), g, exp_b[i]);
    end
    bif.req = 3'b000;
    tick();
    tick();

    // reset while waiting for read data
    bif.wr = 3'b000;
    bif.req = 3'b010;
    tick();
    bif.req = 3'b000;
    bif.mem_ack = 1'b1;
    tick();
    bif.mem_ack = 1'b0;
    check("rr_in_wait", bif.mem_req, 0);
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("mid_rst_req", bif.mem_req, 0);
    check("mid_rst_ack", bif.ack, 0);
    bif.mem_rvalid = 1'b1;
    bif.mem_rdata = 32'hCAFEF00D;
    tick();
    bif.mem_rvalid = 1'b0;
    check("mid_rst_rv_ign", bif.ack, 0);
    tick();
    check("mid_rst_rv_ign2", bif.ack, 0);
    check("mid_rst_rdata", bif.rdata, 0);
    bif.wr = 3'b001;
    bif.req = 3'b001;
    serve(g);
    bif.req = 3'b000;
    check("post_rst_grant", g, 0);
    check("post_rst_ack", bif.ack, 3'b001);

    tick();
    check("ack_onehot", bad_ack, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
